uart_tx_fifo_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_byte_fifo.sv | 55 +++++
 rtl/uart_tx_fifo_ctrl.sv | 113 +++++++++++
 tb/tb_uart_tx_fifo_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encodings common to the TX and RX sides,
// default bit timing and frame geometry.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'b000,
    TX_START_BIT = 3'b001,
    TX_DATA_BITS = 3'b010,
    TX_STOP_BIT  = 3'b011
  } uart_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 217;
  localparam int FRAME_BITS           = 10;
  localparam int DATA_BITS            = 8;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte-wide circular FIFO with a full-range occupancy count; writes while full
// and pops while empty are ignored.
module uart_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_pop;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign do_wr  = wr_en && !full;
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  // NOTE: storage has no reset; count gates every read, so stale bytes are never visible.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Power-of-two depth: pointers wrap naturally at their width.
      if (do_wr)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// 8N1 UART transmitter fed by a byte FIFO; FSM, bit timing and shift register live here,
// and every line-side output is registered one clock behind the state that selects it.
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_n,
  input  logic                          i_TX_DV,
  input  logic [7:0]                    i_TX_Byte,
  output logic                          o_TX_Ready,
  output logic                          o_TX_Serial,
  output logic                          o_TX_Active,
  output logic                          o_TX_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count
);

  localparam int                 CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]         LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_t      state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_index;
  logic [7:0]       shift;
  logic [7:0]       fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  assign pop        = (state == IDLE) && !fifo_empty;
  assign o_TX_Ready = !fifo_full;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_Clock),
    .rst_n   (i_Rst_n),
    .wr_en   (i_TX_DV),
    .wr_data (i_TX_Byte),
    .pop     (pop),
    .head    (fifo_head),
    .count   (o_FIFO_Count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_index   <= '0;
      shift       <= '0;
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      o_TX_Done <= 1'b0;
      case (state)
        IDLE: begin
          o_TX_Serial <= 1'b1;
          o_TX_Active <= 1'b0;
          if (!fifo_empty) begin
            shift     <= fifo_head;
            clk_cnt   <= '0;
            bit_index <= '0;
            state     <= TX_START_BIT;
          end
        end
        TX_START_BIT: begin
          o_TX_Serial <= 1'b0;
          o_TX_Active <= 1'b1;
          if (clk_cnt == LAST_CLK) begin
            clk_cnt <= '0;
            state   <= TX_DATA_BITS;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        TX_DATA_BITS: begin
          o_TX_Serial <= shift[bit_index];
          o_TX_Active <= 1'b1;
          if (clk_cnt == LAST_CLK) begin
            clk_cnt <= '0;
            if (bit_index == LAST_BIT) begin
              state <= TX_STOP_BIT;
            end else begin
              bit_index <= bit_index + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        TX_STOP_BIT: begin
          o_TX_Serial <= 1'b1;
          o_TX_Active <= 1'b1;
          if (clk_cnt == LAST_CLK) begin
            // Registered here, so the pulse lands on the final clock of the stop bit on the line.
            o_TX_Done <= 1'b1;
            clk_cnt   <= '0;
            state     <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Bench for uart_tx_fifo_ctrl: frame-level reference model, table-driven queue fill,
// hand-written corner sequences, random traffic and a full-speed bit timing check.
module tb_uart_tx_fifo_ctrl;

  localparam int CPB        = 4;
  localparam int DEPTH      = 4;
  localparam int FRAME_CLKS = 10 * CPB;
  localparam int SLOW_CPB   = 217;
  localparam int SLOW_FRAME = 10 * SLOW_CPB;

  logic       clk;
  logic       rst_n;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_active;
  logic       tx_done;
  logic [2:0] fifo_count;

  logic       s_dv;
  logic [7:0] s_byte;
  logic       s_ready;
  logic       s_serial;
  logic       s_active;
  logic       s_done;
  logic [2:0] s_count;

  uart_tx_fifo_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) u_dut (
    .i_Clock      (clk),
    .i_Rst_n      (rst_n),
    .i_TX_DV      (tx_dv),
    .i_TX_Byte    (tx_byte),
    .o_TX_Ready   (tx_ready),
    .o_TX_Serial  (tx_serial),
    .o_TX_Active  (tx_active),
    .o_TX_Done    (tx_done),
    .o_FIFO_Count (fifo_count)
  );

  uart_tx_fifo_ctrl #(.CLKS_PER_BIT(SLOW_CPB), .FIFO_DEPTH(DEPTH)) u_dut_slow (
    .i_Clock      (clk),
    .i_Rst_n      (rst_n),
    .i_TX_DV      (s_dv),
    .i_TX_Byte    (s_byte),
    .o_TX_Ready   (s_ready),
    .o_TX_Serial  (s_serial),
    .o_TX_Active  (s_active),
    .o_TX_Done    (s_done),
    .o_FIFO_Count (s_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue of accepted bytes plus the single frame on the line,
  // described by the edge it was popped at.
  logic [7:0] mq[$];
  longint     edge_num    = 0;
  longint     t_free      = 0;
  longint     pop_edge    = 0;
  logic [7:0] cur_byte    = '0;
  logic       frame_valid = 1'b0;
  int         done_seen   = 0;
  int         low_seen    = 0;
  int         active_seen = 0;

  task automatic model_reset();
    mq.delete();
    frame_valid = 1'b0;
    t_free      = 0;
  endtask

  task automatic model_edge(input logic dv, input logic [7:0] data);
    int cnt_before;
    edge_num++;
    cnt_before = mq.size();
    if (cnt_before > 0 && edge_num >= t_free) begin
      cur_byte    = mq.pop_front();
      pop_edge    = edge_num;
      frame_valid = 1'b1;
      t_free      = edge_num + FRAME_CLKS + 1;
    end
    if (dv && cnt_before != DEPTH) mq.push_back(data);
  endtask

  task automatic compare_model();
    int   k;
    int   b;
    logic es;
    logic ea;
    logic ed;
    es = 1'b1;
    ea = 1'b0;
    ed = 1'b0;
    if (frame_valid) begin
      k = int'(edge_num - pop_edge);
      if (k >= 1 && k <= FRAME_CLKS) begin
        b  = (k - 1) / CPB;
        ea = 1'b1;
        ed = (k == FRAME_CLKS);
        if (b == 0)      es = 1'b0;
        else if (b == 9) es = 1'b1;
        else             es = cur_byte[b-1];
      end
    end
    check("serial", tx_serial, es);
    check("active", tx_active, ea);
    check("done",   tx_done,   ed);
    check("count",  fifo_count, mq.size());
    check("ready",  tx_ready,  mq.size() != DEPTH);
    if (tx_done)    done_seen++;
    if (!tx_serial) low_seen++;
    if (tx_active)  active_seen++;
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge, compare at the next falling edge.
  task automatic step(input logic dv, input logic [7:0] data);
    tx_dv   = dv;
    tx_byte = data;
    @(posedge clk);
    model_edge(dv, data);
    @(negedge clk);
    compare_model();
  endtask

  typedef struct {
    logic       dv;
    logic [7:0] data;
    int         exp_count;
    logic       exp_ready;
    logic       exp_serial;
  } vec_t;

  vec_t fill_tab[7];
  int   phase_pct[4];
  logic slow_line[SLOW_FRAME];
  logic slow_done[SLOW_FRAME];

  initial begin
    int         first_low;
    int         lat;
    logic       found;
    int         match;
    int         nact;
    int         ndone;
    logic [7:0] rx_byte;
    logic [7:0] sb;
    logic       eb;

    fill_tab[0] = '{1'b1, 8'hA1, 1, 1'b1, 1'b1};
    fill_tab[1] = '{1'b1, 8'hB2, 1, 1'b1, 1'b1};
    fill_tab[2] = '{1'b1, 8'hC3, 2, 1'b1, 1'b0};
    fill_tab[3] = '{1'b1, 8'hD4, 3, 1'b1, 1'b0};
    fill_tab[4] = '{1'b1, 8'hE5, 4, 1'b0, 1'b0};
    fill_tab[5] = '{1'b1, 8'hF6, 4, 1'b0, 1'b0};
    fill_tab[6] = '{1'b0, 8'h00, 4, 1'b0, 1'b1};
    phase_pct   = '{70, 10, 95, 30};

    tx_dv   = 1'b0;
    tx_byte = '0;
    s_dv    = 1'b0;
    s_byte  = '0;
    rst_n   = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_serial", tx_serial, 1'b1);
    check("rst_active", tx_active, 1'b0);
    check("rst_done",   tx_done,   1'b0);
    check("rst_count",  fifo_count, 0);
    check("rst_ready",  tx_ready,  1'b1);
    rst_n = 1'b1;

    // Idle after reset.
    done_seen = 0;
    for (int i = 0; i < 100; i++) step(1'b0, 8'h00);
    check("idle_done_pulses", done_seen, 0);

    // Single byte 0x55.
    done_seen = 0; low_seen = 0; active_seen = 0; first_low = -1;
    step(1'b1, 8'h55);
    for (int i = 1; i <= 45; i++) begin
      step(1'b0, 8'h00);
      if (!tx_serial && first_low < 0) first_low = i;
    end
    check("x55_first_low_edge", first_low, 2);
    check("x55_low_clocks", low_seen, 20);
    check("x55_active_clocks", active_seen, FRAME_CLKS);
    check("x55_done_pulses", done_seen, 1);

    // Queue fill from idle: table of consecutive writes.
    done_seen = 0;
    for (int i = 0; i < 7; i++) begin
      step(fill_tab[i].dv, fill_tab[i].data);
      check("fill_count",  fifo_count, fill_tab[i].exp_count);
      check("fill_ready",  tx_ready,   fill_tab[i].exp_ready);
      check("fill_serial", tx_serial,  fill_tab[i].exp_serial);
    end
    for (int i = 0; i < 5 * (FRAME_CLKS + 1) + 10; i++) step(1'b0, 8'h00);
    check("fill_done_pulses", done_seen, 5);
    check("fill_drained", fifo_count, 0);

    // Write lands on the same edge the FSM pops the only queued byte.
    done_seen = 0;
    step(1'b1, 8'h11);
    check("sim_count_before", fifo_count, 1);
    step(1'b1, 8'h3C);
    check("sim_count_after", fifo_count, 1);
    for (int i = 0; i < 2 * (FRAME_CLKS + 1) + 5; i++) step(1'b0, 8'h00);
    check("sim_done_pulses", done_seen, 2);

    // Reset during data bit 3 of 0x00 with two bytes queued.
    step(1'b1, 8'h00);
    step(1'b1, 8'hAA);
    step(1'b1, 8'hBB);
    for (int i = 0; i < 17; i++) step(1'b0, 8'h00);
    check("pre_rst_line", tx_serial, 1'b0);
    check("pre_rst_count", fifo_count, 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_line", tx_serial, 1'b1);
    check("async_rst_count", fifo_count, 0);
    check("async_rst_done", tx_done, 1'b0);
    check("async_rst_active", tx_active, 1'b0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    done_seen = 0; low_seen = 0;
    for (int i = 0; i < 60; i++) step(1'b0, 8'h00);
    check("post_rst_low_clocks", low_seen, 0);
    check("post_rst_done_pulses", done_seen, 0);

    // Random traffic in phases of differing write pressure.
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 400; i++) begin
        step(($urandom_range(0, 99) < phase_pct[p]), 8'($urandom));
      end
    end
    for (int i = 0; i < (DEPTH + 1) * (FRAME_CLKS + 1) + 5; i++) step(1'b0, 8'h00);
    check("rand_drained", fifo_count, 0);

    // Full-speed instance: 0x0F, every bit 217 clocks, mid-bit sampling recovers the byte.
    s_dv   = 1'b1;
    s_byte = 8'h0F;
    @(posedge clk);
    @(negedge clk);
    s_dv  = 1'b0;
    found = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 10 && !found; i++) begin
      @(negedge clk);
      if (!s_serial) begin
        found = 1'b1;
        lat   = i;
      end
    end
    check("slow_latency", lat, 2);
    nact = 0;
    ndone = 0;
    for (int i = 0; i < SLOW_FRAME; i++) begin
      if (i > 0) @(negedge clk);
      slow_line[i] = s_serial;
      slow_done[i] = s_done;
      if (s_active) nact++;
      if (s_done)   ndone++;
    end
    sb = 8'h0F;
    for (int j = 0; j < 10; j++) begin
      if (j == 0)      eb = 1'b0;
      else if (j == 9) eb = 1'b1;
      else             eb = sb[j-1];
      match = 0;
      for (int s = 0; s < SLOW_CPB; s++) begin
        if (slow_line[j * SLOW_CPB + s] == eb) match++;
      end
      check("slow_bit_clocks", match, SLOW_CPB);
    end
    rx_byte = '0;
    for (int j = 1; j <= 8; j++) rx_byte[j-1] = slow_line[j * SLOW_CPB + SLOW_CPB / 2];
    check("slow_rx_byte", rx_byte, 8'h0F);
    check("slow_active_clocks", nact, SLOW_FRAME);
    check("slow_done_pulses", ndone, 1);
    check("slow_done_position", slow_done[SLOW_FRAME-1], 1'b1);
    @(negedge clk);
    check("slow_line_idle_after", s_serial, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
